// File: rtl/dragon_spawn_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dragon_sched_pkg
//  Description : Shared types and difficulty tables for the dragon spawn
//                scheduler. Tables are indexed by the 2-bit level (0..3).
//                  WIN_LO / WIN_HI : RNG acceptance window [WIN_LO, WIN_HI)
//                  MAX_ACTIVE      : cap on dragons simultaneously in flight
//                  GAP_FRAMES      : frames of cooldown loaded after a spawn
//  Revision    : 1.0  initial release
// ============================================================================
package dragon_sched_pkg;

    typedef enum logic [1:0] {
        S_COOLDOWN = 2'd0,
        S_ARMED    = 2'd1,
        S_SPAWN    = 2'd2
    } sched_state_t;

    localparam logic [10:0]      WIN_LO     = 11'd500;
    // Packed tables: element [0] is the last item of each concatenation.
    localparam logic [3:0][10:0] WIN_HI     = {11'd800, 11'd700, 11'd620, 11'd560};
    localparam logic [3:0][2:0]  MAX_ACTIVE = {3'd3, 3'd2, 3'd2, 3'd1};
    localparam logic [3:0][7:0]  GAP_FRAMES = {8'd40, 8'd60, 8'd90, 8'd120};

    // Unsigned window test of the random value against the level's window.
    function automatic logic rng_in_window(input logic [10:0] rng,
                                           input logic [1:0]  lvl);
        return (rng >= WIN_LO) && (rng < WIN_HI[lvl]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dragon_spawn_scheduler_picker.sv
`default_nettype none
// ============================================================================
//  Module      : dragon_slot_picker
//  Description : Combinational round-robin finder. Returns the first idle
//                slot scanning upward from (lastSel+1) mod NUM_DRAGONS with
//                wrap-around.
//  Ports       : active  [NUM_DRAGONS] in  - slot busy flags
//                lastSel [SEL_W]       in  - most recently spawned slot
//                sel     [SEL_W]       out - chosen idle slot (0 if none)
//                anyIdle               out - at least one slot is idle
//  Revision    : 1.0  initial release
// ============================================================================
module dragon_slot_picker
    import dragon_sched_pkg::*;
#(
    parameter int NUM_DRAGONS = 3,
    parameter int SEL_W       = 2
)(
    input  logic [NUM_DRAGONS-1:0] active,
    input  logic [SEL_W-1:0]       lastSel,
    output logic [SEL_W-1:0]       sel,
    output logic                   anyIdle
);

    // One extra bit: start + offset reaches at most 2*NUM_DRAGONS-1.
    logic [SEL_W:0]               w_start;
    logic [SEL_W:0]               w_idx;
    logic [2*NUM_DRAGONS-1:0]     w_rot;

    always_comb begin
        w_start = {1'b0, lastSel} + (SEL_W+1)'(1);
        // Doubling the vector turns the wrap-around scan into a plain shift:
        // bit k of w_rot is slot (lastSel+1+k) mod NUM_DRAGONS.
        w_rot   = {active, active} >> w_start;
        w_idx   = '0;
        anyIdle = 1'b0;
        // Scan from the far end so the nearest idle slot is written last.
        for (int k = NUM_DRAGONS - 1; k >= 0; k--) begin
            if (!w_rot[k]) begin
                w_idx   = w_start + (SEL_W+1)'(k);
                anyIdle = 1'b1;
            end
        end
        if (w_idx >= (SEL_W+1)'(NUM_DRAGONS)) begin
            w_idx = w_idx - (SEL_W+1)'(NUM_DRAGONS);
        end
        sel = w_idx[SEL_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/dragon_spawn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : dragon_spawn_scheduler
//  Description : Decides once per frame whether an idle dragon slot is
//                released. Enforces an inter-spawn cooldown, a per-level cap
//                on dragons in flight and an RNG-gated spawn window. Tracks
//                which slots are in flight and keeps saturating spawn/kill
//                totals.
//  Ports       : clk, resetN (async, active-low)
//                startOfFrame  in  one-clk frame pulse
//                pause         in  freezes frame-rate scheduling
//                RNG[10:0]     in  random value, used on frame ticks
//                level[1:0]    in  difficulty level, used on frame ticks
//                dragonDone[N] in  per-slot "left the screen" pulse
//                dragonHit[N]  in  per-slot "killed" pulse
//                spawn[N]      out one-hot unleash pulse
//                active[N]     out slot in flight
//                activeCount   out popcount of active
//                spawnTotal    out saturating spawn count
//                killTotal     out saturating hit count
//  Revision    : 1.0  initial release
// ============================================================================
module dragon_spawn_scheduler
    import dragon_sched_pkg::*;
#(
    parameter int NUM_DRAGONS        = 3,
    parameter int FIRST_DELAY_FRAMES = 60
)(
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   pause,
    input  logic [10:0]            RNG,
    input  logic [1:0]             level,
    input  logic [NUM_DRAGONS-1:0] dragonDone,
    input  logic [NUM_DRAGONS-1:0] dragonHit,
    output logic [NUM_DRAGONS-1:0] spawn,
    output logic [NUM_DRAGONS-1:0] active,
    output logic [2:0]             activeCount,
    output logic [7:0]             spawnTotal,
    output logic [7:0]             killTotal
);

    localparam int               SEL_W       = (NUM_DRAGONS > 1) ? $clog2(NUM_DRAGONS) : 1;
    localparam logic [2:0]       c_NUM_SLOTS = 3'(NUM_DRAGONS);
    localparam logic [SEL_W-1:0] c_LAST_RST  = SEL_W'(NUM_DRAGONS - 1);
    localparam logic [7:0]       c_FIRST_GAP = 8'(FIRST_DELAY_FRAMES);

    sched_state_t           r_state;
    sched_state_t           w_state_nxt;
    logic [7:0]             r_gapCnt;
    logic [7:0]             w_gap_nxt;
    logic [SEL_W-1:0]       r_lastSel;
    logic [1:0]             r_armLevel;
    logic [NUM_DRAGONS-1:0] r_spawn;
    logic [NUM_DRAGONS-1:0] r_active;
    logic [2:0]             r_activeCount;
    logic [7:0]             r_spawnTotal;
    logic [7:0]             r_killTotal;

    logic                   w_tick;
    logic [2:0]             w_cap;
    logic                   w_armOk;
    logic                   w_arm;
    logic [SEL_W-1:0]       w_sel;
    logic                   w_anyIdle;
    logic [NUM_DRAGONS-1:0] w_setMask;
    logic [NUM_DRAGONS-1:0] w_active_nxt;
    logic [2:0]             w_activeCnt_nxt;
    logic [2:0]             w_hitCnt;
    logic [8:0]             w_killSum;

    dragon_slot_picker #(
        .NUM_DRAGONS (NUM_DRAGONS),
        .SEL_W       (SEL_W)
    ) u_picker (
        .active  (r_active),
        .lastSel (r_lastSel),
        .sel     (w_sel),
        .anyIdle (w_anyIdle)
    );

    assign w_tick  = startOfFrame & ~pause;
    assign w_cap   = (MAX_ACTIVE[level] > c_NUM_SLOTS) ? c_NUM_SLOTS : MAX_ACTIVE[level];
    assign w_armOk = (r_activeCount < w_cap) && w_anyIdle && rng_in_window(RNG, level);

    // ------------------------------------------------------------------
    // Next-state logic. The tick on which the cooldown expires is also the
    // first armed tick, so consecutive spawns are GAP_FRAMES+1 ticks apart.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gapCnt;
        w_arm       = 1'b0;
        case (r_state)
            S_COOLDOWN: begin
                if (w_tick) begin
                    if (r_gapCnt != 8'd0) begin
                        w_gap_nxt = r_gapCnt - 8'd1;
                    end else if (w_armOk) begin
                        w_arm       = 1'b1;
                        w_state_nxt = S_SPAWN;
                    end else begin
                        w_state_nxt = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                if (w_tick && w_armOk) begin
                    w_arm       = 1'b1;
                    w_state_nxt = S_SPAWN;
                end
            end
            S_SPAWN: begin
                // Ticks are not examined here; the pulse clk always completes.
                w_gap_nxt   = GAP_FRAMES[r_armLevel];
                w_state_nxt = S_COOLDOWN;
            end
            default: begin
                w_state_nxt = S_COOLDOWN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_COOLDOWN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Slot bookkeeping. The spawn-related registers load on the arming edge
    // so spawn, active[sel] and spawnTotal all change together during the
    // S_SPAWN clk. The set is OR-ed after the clears so it wins a collision.
    // ------------------------------------------------------------------
    always_comb begin
        w_setMask       = w_arm ? (NUM_DRAGONS'(1) << w_sel) : '0;
        w_active_nxt    = (r_active & ~(dragonDone | dragonHit)) | w_setMask;
        w_activeCnt_nxt = '0;
        w_hitCnt        = '0;
        for (int i = 0; i < NUM_DRAGONS; i++) begin
            w_activeCnt_nxt = w_activeCnt_nxt + {2'b00, w_active_nxt[i]};
            w_hitCnt        = w_hitCnt + {2'b00, dragonHit[i]};
        end
        w_killSum = {1'b0, r_killTotal} + {6'b000000, w_hitCnt};
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_gapCnt      <= c_FIRST_GAP;
            r_lastSel     <= c_LAST_RST;
            r_armLevel    <= 2'd0;
            r_spawn       <= '0;
            r_active      <= '0;
            r_activeCount <= 3'd0;
            r_spawnTotal  <= 8'd0;
            r_killTotal   <= 8'd0;
        end else begin
            r_gapCnt      <= w_gap_nxt;
            r_spawn       <= w_setMask;
            r_active      <= w_active_nxt;
            r_activeCount <= w_activeCnt_nxt;
            r_killTotal   <= w_killSum[8] ? 8'hFF : w_killSum[7:0];
            if (w_arm) begin
                r_lastSel  <= w_sel;
                r_armLevel <= level;
                if (r_spawnTotal != 8'hFF) begin
                    r_spawnTotal <= r_spawnTotal + 8'd1;
                end
            end
        end
    end

    assign spawn       = r_spawn;
    assign active      = r_active;
    assign activeCount = r_activeCount;
    assign spawnTotal  = r_spawnTotal;
    assign killTotal   = r_killTotal;

endmodule
`default_nettype wire
